// File: rtl/vpg_mode_sequencer.sv
// vpg_mode_sequencer: upstream control stage for the VPG PLL reconfiguration FSM.
// Synchronizes and debounces the board mode switches, sequences a mode change
// (hold VPG in reset, one-cycle reconfig request, wait for unlock/relock),
// and releases the video timing generator once the PLL lock has been stable.
// Optional build macro MODE_SEQ_RETRY_EN: retry a lock timeout up to MAX_RETRIES
// times before declaring a lock failure.
module vpg_mode_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int HOLD_CYCLES     = 16,
    parameter int UNLOCK_TIMEOUT  = 256,
    parameter int LOCK_STABLE     = 1024,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic [2:0] mode_sel,
    input  logic       pll_locked,
    output logic [2:0] timing_mode,
    output logic       timing_mode_change,
    output logic       vpg_reset_n,
    output logic       busy,
    output logic       lock_error
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_PARAM = max_of(max_of(max_of(DEBOUNCE_CYCLES, HOLD_CYCLES),
                                             max_of(UNLOCK_TIMEOUT, LOCK_STABLE)),
                                      max_of(LOCK_TIMEOUT, MAX_RETRIES));
    localparam int CW = $clog2(MAX_PARAM) + 1;

    // The debounce accepts on the enabled cycle whose increment would bring
    // db_cnt to DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES stable cycles.
    localparam int DB_LAST_I = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [CW-1:0] DB_LAST      = CW'(DB_LAST_I);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] UNLOCK_LAST  = CW'(UNLOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        REQ,
        WAIT_UNLOCK,
        WAIT_LOCK,
        ERROR
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0]    mode_pipe [SYNC_STAGES];
    logic          locked_pipe [SYNC_STAGES];
    logic [2:0]    mode_sync;
    logic          locked_sync;
    logic [2:0]    mode_prev;
    logic [2:0]    accepted_mode;
    logic [CW-1:0] db_cnt;
    logic          db_accept;
    logic          pending;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] stable_cnt;

`ifdef MODE_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES);
    logic [RW-1:0] retry_cnt;
`endif

    assign mode_sync   = mode_pipe[SYNC_STAGES-1];
    assign locked_sync = locked_pipe[SYNC_STAGES-1];

    // Free-running synchronizer chains for the asynchronous switch and lock inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                mode_pipe[i]   <= 3'd0;
                locked_pipe[i] <= 1'b0;
            end
        end else begin
            mode_pipe[0]   <= mode_sel;
            locked_pipe[0] <= pll_locked;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mode_pipe[i]   <= mode_pipe[i-1];
                locked_pipe[i] <= locked_pipe[i-1];
            end
        end
    end

    assign db_accept = (mode_sync == mode_prev) && (mode_sync != accepted_mode) &&
                       (db_cnt == DB_LAST);

    // Debounce: a new mode must hold steady for the full window before it is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_prev     <= 3'd0;
            accepted_mode <= 3'd0;
            db_cnt        <= '0;
        end else if (clk_en) begin
            mode_prev <= mode_sync;
            if ((mode_sync != mode_prev) || (mode_sync == accepted_mode)) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                accepted_mode <= mode_sync;
                db_cnt        <= '0;
            end else begin
                db_cnt <= sat_inc(db_cnt);
            end
        end
    end

    // Sequencer FSM: applies pending modes and walks the PLL retune handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            timing_mode        <= 3'd0;
            timing_mode_change <= 1'b0;
            vpg_reset_n        <= 1'b0;
            busy               <= 1'b1;
            lock_error         <= 1'b0;
            pending            <= 1'b1;
            cnt                <= '0;
            stable_cnt         <= '0;
`ifdef MODE_SEQ_RETRY_EN
            retry_cnt          <= '0;
`endif
        end else if (clk_en) begin
            timing_mode_change <= 1'b0;
            if (db_accept) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE, ERROR: begin
                    if (pending) begin
                        timing_mode <= accepted_mode;
                        pending     <= db_accept;
                        lock_error  <= 1'b0;
                        vpg_reset_n <= 1'b0;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        state       <= HOLD;
`ifdef MODE_SEQ_RETRY_EN
                        retry_cnt   <= '0;
`endif
                    end else if (state == IDLE) begin
                        busy <= db_accept;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt                <= '0;
                        timing_mode_change <= 1'b1;
                        state              <= REQ;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                REQ: begin
                    cnt   <= '0;
                    state <= WAIT_UNLOCK;
                end
                WAIT_UNLOCK: begin
                    if (!locked_sync || (cnt == UNLOCK_LAST)) begin
                        cnt        <= '0;
                        stable_cnt <= '0;
                        state      <= WAIT_LOCK;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_sync && (stable_cnt == STABLE_LAST)) begin
                        vpg_reset_n <= 1'b1;
                        busy        <= pending | db_accept;
                        cnt         <= '0;
                        stable_cnt  <= '0;
                        state       <= IDLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt        <= '0;
                        stable_cnt <= '0;
`ifdef MODE_SEQ_RETRY_EN
                        if (retry_cnt == RETRY_LAST) begin
                            lock_error <= 1'b1;
                            state      <= ERROR;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= HOLD;
                        end
`else
                        lock_error <= 1'b1;
                        state      <= ERROR;
`endif
                    end else begin
                        cnt        <= sat_inc(cnt);
                        stable_cnt <= locked_sync ? sat_inc(stable_cnt) : '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// tb_vpg_mode_sequencer: directed self-checking bench for vpg_mode_sequencer.
// Uses shortened timing parameters so full mode sequences fit in a few hundred cycles.
module tb_vpg_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_en;
    logic [2:0] mode_sel;
    logic       pll_locked;
    logic [2:0] timing_mode;
    logic       timing_mode_change;
    logic       vpg_reset_n;
    logic       busy;
    logic       lock_error;

    int n_checks = 0;
    int n_fail   = 0;

    int  cyc       = 0;
    int  en_div    = 1;
    int  pulse_cnt = 0;
    int  pulse_mode = 0;
    bit  pulse_now = 1'b0;
    bit  prev_tmc  = 1'b0;
    int  tmc_run   = 0;
    int  last_run  = 0;
    int  tm_changes = 0;
    logic [2:0] prev_tm = 3'd0;

`ifdef MODE_SEQ_RETRY_EN
    localparam int EXP_TIMEOUT_PULSES = 4;
    localparam int EXP_TIMEOUT_CYCLES = 277;
`else
    localparam int EXP_TIMEOUT_PULSES = 1;
    localparam int EXP_TIMEOUT_CYCLES = 67;
`endif

    vpg_mode_sequencer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(4), .UNLOCK_TIMEOUT(16),
        .LOCK_STABLE(8), .LOCK_TIMEOUT(64), .MAX_RETRIES(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .mode_sel(mode_sel),
        .pll_locked(pll_locked), .timing_mode(timing_mode),
        .timing_mode_change(timing_mode_change), .vpg_reset_n(vpg_reset_n),
        .busy(busy), .lock_error(lock_error)
    );

    always #5 clk = ~clk;

    // Advance one clk, sample 1ns after the edge, update the enable pattern and monitors
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        clk_en = (en_div <= 1) ? 1'b1 : ((cyc % en_div) == 0);
        pulse_now = timing_mode_change && !prev_tmc;
        if (pulse_now) begin
            pulse_cnt++;
            pulse_mode = int'(timing_mode);
            tmc_run = 0;
        end
        if (timing_mode_change) tmc_run++;
        if (!timing_mode_change && prev_tmc) last_run = tmc_run;
        prev_tmc = timing_mode_change;
        if (timing_mode !== prev_tm) tm_changes++;
        prev_tm = timing_mode;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pulse(input int max_cycles, output int n, output bit seen);
        seen = 1'b0;
        n = 0;
        while (!seen && n < max_cycles) begin
            cycle();
            n++;
            if (pulse_now) seen = 1'b1;
        end
    endtask

    task automatic wait_release(input int max_cycles, output int n, output bit seen);
        pll_locked = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < max_cycles) begin
            cycle();
            n++;
            if (vpg_reset_n === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        reset_n = 1'b0; clk_en = 1'b1; mode_sel = 3'd0; pll_locked = 1'b1;
        run(3);
        n_checks++; if (timing_mode !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_timing_mode: got %0d expected 0", timing_mode); end
        n_checks++; if (timing_mode_change !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_change: got %b expected 0", timing_mode_change); end
        n_checks++; if (vpg_reset_n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vpg_reset_n: got %b expected 0", vpg_reset_n); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
        n_checks++; if (lock_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_lock_error: got %b expected 0", lock_error); end
        reset_n = 1'b1;
        wait_pulse(30, n, ok);
        n_checks++; if (!ok || n != 5) begin n_fail++; $display("[TB] FAIL reset_pulse_latency: got %0d (seen %b) expected 5", n, ok); end
        n_checks++; if (vpg_reset_n !== 1'b0 || pulse_mode != 0) begin n_fail++; $display("[TB] FAIL reset_hold: vpg %b mode %0d expected 0 and 0", vpg_reset_n, pulse_mode); end
        pll_locked = 1'b0;
        run(3);
        wait_release(60, n, ok);
        n_checks++; if (!ok || n != 10) begin n_fail++; $display("[TB] FAIL reset_release_latency: got %0d (seen %b) expected 10", n, ok); end
        n_checks++; if (busy !== 1'b0 || pulse_cnt != 1) begin n_fail++; $display("[TB] FAIL reset_done: busy %b pulses %0d expected 0 and 1", busy, pulse_cnt); end
    endtask

    task automatic test_glitch();
        int p0 = pulse_cnt;
        bit busy_seen = 1'b0;
        mode_sel = 3'd5;
        for (int i = 0; i < 5; i++) begin cycle(); if (busy) busy_seen = 1'b1; end
        mode_sel = 3'd0;
        for (int i = 0; i < 30; i++) begin cycle(); if (busy) busy_seen = 1'b1; end
        n_checks++; if (busy_seen || pulse_cnt != p0) begin n_fail++; $display("[TB] FAIL glitch_ignored: busy_seen %b pulses %0d expected 0 and %0d", busy_seen, pulse_cnt, p0); end
        n_checks++; if (timing_mode !== 3'd0 || vpg_reset_n !== 1'b1) begin n_fail++; $display("[TB] FAIL glitch_state: mode %0d vpg %b expected 0 and 1", timing_mode, vpg_reset_n); end
    endtask

    task automatic test_mode_change();
        int n;
        bit ok;
        mode_sel = 3'd3;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin cycle(); n++; end
        n_checks++; if (n != 10) begin n_fail++; $display("[TB] FAIL accept_latency: got %0d expected 10", n); end
        cycle();
        n_checks++; if (vpg_reset_n !== 1'b0 || timing_mode !== 3'd3) begin n_fail++; $display("[TB] FAIL hold_entry: vpg %b mode %0d expected 0 and 3", vpg_reset_n, timing_mode); end
        wait_pulse(20, n, ok);
        n_checks++; if (!ok || n != 4 || pulse_mode != 3) begin n_fail++; $display("[TB] FAIL mode3_pulse: after %0d mode %0d (seen %b) expected 4 and 3", n, pulse_mode, ok); end
        pll_locked = 1'b0;
        run(3);
        wait_release(60, n, ok);
        n_checks++; if (!ok || n != 10) begin n_fail++; $display("[TB] FAIL mode3_release: got %0d (seen %b) expected 10", n, ok); end
        cycle();
        n_checks++; if (busy !== 1'b0 || timing_mode !== 3'd3) begin n_fail++; $display("[TB] FAIL mode3_done: busy %b mode %0d expected 0 and 3", busy, timing_mode); end
    endtask

    task automatic test_mid_sequence();
        int n;
        bit ok;
        int p0 = pulse_cnt;
        int t0 = tm_changes;
        mode_sel = 3'd1;
        wait_pulse(30, n, ok);
        n_checks++; if (!ok || n != 15 || pulse_mode != 1) begin n_fail++; $display("[TB] FAIL mid_first_pulse: after %0d mode %0d (seen %b) expected 15 and 1", n, pulse_mode, ok); end
        pll_locked = 1'b0;
        run(3);
        mode_sel = 3'd6;
        run(15);
        n_checks++; if (timing_mode !== 3'd1 || busy !== 1'b1 || vpg_reset_n !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_hold_mode: mode %0d busy %b vpg %b expected 1, 1, 0", timing_mode, busy, vpg_reset_n); end
        wait_release(60, n, ok);
        n_checks++; if (!ok || n != 10 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_first_release: after %0d busy %b (seen %b) expected 10 and 1", n, busy, ok); end
        wait_pulse(20, n, ok);
        n_checks++; if (!ok || n != 5 || pulse_mode != 6) begin n_fail++; $display("[TB] FAIL mid_second_pulse: after %0d mode %0d (seen %b) expected 5 and 6", n, pulse_mode, ok); end
        pll_locked = 1'b0;
        run(3);
        wait_release(60, n, ok);
        cycle();
        n_checks++; if (!ok || busy !== 1'b0 || timing_mode !== 3'd6) begin n_fail++; $display("[TB] FAIL mid_done: busy %b mode %0d (seen %b) expected 0 and 6", busy, timing_mode, ok); end
        n_checks++; if (pulse_cnt - p0 != 2 || tm_changes - t0 != 2) begin n_fail++; $display("[TB] FAIL mid_counts: pulses %0d mode_changes %0d expected 2 and 2", pulse_cnt - p0, tm_changes - t0); end
    endtask

    task automatic test_lock_timeout();
        int n;
        bit ok;
        int p0 = pulse_cnt;
        mode_sel = 3'd4;
        wait_pulse(30, n, ok);
        pll_locked = 1'b0;
        n = 0;
        while (lock_error !== 1'b1 && n < 600) begin cycle(); n++; end
        n_checks++; if (!ok || n != EXP_TIMEOUT_CYCLES) begin n_fail++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", n, EXP_TIMEOUT_CYCLES); end
        n_checks++; if (vpg_reset_n !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL error_state: vpg %b busy %b expected 0 and 1", vpg_reset_n, busy); end
        n_checks++; if (pulse_cnt - p0 != EXP_TIMEOUT_PULSES) begin n_fail++; $display("[TB] FAIL timeout_pulses: got %0d expected %0d", pulse_cnt - p0, EXP_TIMEOUT_PULSES); end
        run(20);
        n_checks++; if (lock_error !== 1'b1) begin n_fail++; $display("[TB] FAIL error_sticky: got %b expected 1", lock_error); end
        mode_sel = 3'd5;
        run(11);
        n_checks++; if (lock_error !== 1'b0 || timing_mode !== 3'd5 || vpg_reset_n !== 1'b0) begin n_fail++; $display("[TB] FAIL error_recover: err %b mode %0d vpg %b expected 0, 5, 0", lock_error, timing_mode, vpg_reset_n); end
        wait_pulse(20, n, ok);
        wait_release(60, n, ok);
        n_checks++; if (!ok || n != 10 || lock_error !== 1'b0) begin n_fail++; $display("[TB] FAIL recover_release: after %0d err %b (seen %b) expected 10 and 0", n, lock_error, ok); end
    endtask

    task automatic test_clk_en();
        int n;
        bit ok;
        en_div = 4;
        mode_sel = 3'd2;
        wait_pulse(200, n, ok);
        n_checks++; if (!ok || pulse_mode != 2) begin n_fail++; $display("[TB] FAIL slow_pulse: mode %0d (seen %b) expected 2", pulse_mode, ok); end
        pll_locked = 1'b0;
        run(12);
        n_checks++; if (last_run != 4) begin n_fail++; $display("[TB] FAIL slow_pulse_width: got %0d expected 4", last_run); end
        wait_release(200, n, ok);
        n_checks++; if (!ok || n < 31 || n > 34) begin n_fail++; $display("[TB] FAIL slow_release: got %0d (seen %b) expected 31..34", n, ok); end
        run(8);
        n_checks++; if (busy !== 1'b0 || timing_mode !== 3'd2) begin n_fail++; $display("[TB] FAIL slow_done: busy %b mode %0d expected 0 and 2", busy, timing_mode); end
        en_div = 1;
    endtask

    // Run each scenario in order, then report
    initial begin
        reset_n = 1'b0; clk_en = 1'b1; mode_sel = 3'd0; pll_locked = 1'b1;
        test_reset();
        test_glitch();
        test_mode_change();
        test_mid_sequence();
        test_lock_timeout();
        test_clk_en();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
